// File: rtl/c2h_packet_gate.sv
// Gates the user-clock FIFO onto the XDMA C2H stream one fixed-size packet at a time,
// regenerating tlast, inserting an idle gap, and counting packets and framing mismatches.
module c2h_packet_gate #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned PKT_WIDTH  = 11,
    parameter int unsigned WAIT_WIDTH = 4
) (
    input  logic                  user_clk,
    input  logic                  user_rstn,
    input  logic                  dma_ena,
    input  logic                  fifo_prog_full,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           pkt_count,
    output logic [15:0]           frame_err_count,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StPass  = 2'd2,
        StGap   = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PKT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [WAIT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
    logic [31:0]           pkt_count_q, pkt_count_d;
    logic [15:0]           frame_err_q, frame_err_d;

    logic in_pass;
    logic xfer;
    logic last_word;

    assign in_pass   = (state_q == StPass);
    assign xfer      = in_pass & s_axis_tvalid & m_axis_tready;
    assign last_word = (word_cnt_q == {PKT_WIDTH{1'b1}});

    // Zero-latency datapath: the FIFO is read directly by the XDMA handshake.
    assign m_axis_tdata    = s_axis_tdata;
    assign m_axis_tkeep    = {KEEP_WIDTH{1'b1}};
    assign m_axis_tvalid   = in_pass & s_axis_tvalid;
    assign s_axis_tready   = in_pass & m_axis_tready;
    assign m_axis_tlast    = in_pass & last_word;
    assign pkt_count       = pkt_count_q;
    assign frame_err_count = frame_err_q;
    assign state_o         = state_q;

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pkt_count_d = pkt_count_q;
        frame_err_d = frame_err_q;

        case (state_q)
            StIdle: begin
                word_cnt_d = '0;
                gap_cnt_d  = '0;
                if (dma_ena) begin
                    state_d     = StArmed;
                    pkt_count_d = '0;
                    frame_err_d = '0;
                end
            end
            StArmed: begin
                if (!dma_ena) begin
                    state_d = StIdle;
                end else if (fifo_prog_full) begin
                    state_d = StPass;
                end
            end
            StPass: begin
                // dma_ena is ignored here so a packet is never truncated.
                if (xfer) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if ((s_axis_tlast != last_word) && (frame_err_q != 16'hFFFF)) begin
                        frame_err_d = frame_err_q + 16'd1;
                    end
                    if (last_word) begin
                        pkt_count_d = pkt_count_q + 32'd1;
                        state_d     = StGap;
                    end
                end
            end
            StGap: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (&gap_cnt_q) begin
                    state_d = dma_ena ? StArmed : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rstn) begin
        if (!user_rstn) begin
            state_q     <= StIdle;
            word_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            pkt_count_q <= '0;
            frame_err_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pkt_count_q <= pkt_count_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_c2h_packet_gate.sv
// Bench for c2h_packet_gate: directed table, corner-case sequences and random traffic
// checked against a packet-level reference model.
module tb_c2h_packet_gate;

    localparam int DW   = 64;
    localparam int KW   = 8;
    localparam int PW   = 4;
    localparam int WW   = 2;
    localparam int PKT  = 16;
    localparam int GAPC = 4;

    localparam int IDLE  = 0;
    localparam int ARMED = 1;
    localparam int PASS  = 2;
    localparam int GAP   = 3;

    logic          user_clk = 1'b0;
    logic          user_rstn;
    logic          dma_ena;
    logic          fifo_prog_full;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [31:0]   pkt_count;
    logic [15:0]   frame_err_count;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;

    // Reference model: phase, words already sent in the packet, gap cycles left.
    int          md_phase;
    int          md_words;
    int          md_gap_left;
    logic [31:0] md_pkts;
    int          md_errs;

    // What the DUT did in the last checked cycle.
    bit          obs_xfer;
    bit          obs_tl;
    logic [DW-1:0] obs_data;
    bit          src_take;

    c2h_packet_gate #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .PKT_WIDTH (PW),
        .WAIT_WIDTH(WW)
    ) dut (
        .user_clk       (user_clk),
        .user_rstn      (user_rstn),
        .dma_ena        (dma_ena),
        .fifo_prog_full (fifo_prog_full),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tlast   (s_tlast),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .pkt_count      (pkt_count),
        .frame_err_count(frame_err_count),
        .state_o        (state_o)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        md_phase    = IDLE;
        md_words    = 0;
        md_gap_left = 0;
        md_pkts     = '0;
        md_errs     = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rise.
    task automatic cycle();
        bit ex;
        @(negedge user_clk);
        chk("state_o", 64'(state_o), 64'(md_phase));
        chk("m_tvalid", 64'(m_tvalid), 64'(md_phase == PASS && s_tvalid));
        chk("s_tready", 64'(s_tready), 64'(md_phase == PASS && m_tready));
        chk("m_tlast", 64'(m_tlast), 64'(md_phase == PASS && md_words == PKT - 1));
        chk("m_tdata", m_tdata, s_tdata);
        chk("m_tkeep", 64'(m_tkeep), 64'hFF);
        chk("pkt_count", 64'(pkt_count), 64'(md_pkts));
        chk("frame_err_count", 64'(frame_err_count), 64'(md_errs));
        obs_xfer = m_tvalid && m_tready;
        obs_tl   = m_tlast;
        obs_data = m_tdata;
        src_take = s_tvalid && s_tready;

        ex = (md_phase == PASS) && s_tvalid && m_tready;
        case (md_phase)
            IDLE: if (dma_ena) begin
                md_phase = ARMED;
                md_pkts  = '0;
                md_errs  = 0;
            end
            ARMED: begin
                if (!dma_ena) md_phase = IDLE;
                else if (fifo_prog_full) md_phase = PASS;
            end
            PASS: if (ex) begin
                if (s_tlast != (md_words == PKT - 1) && md_errs < 65535) md_errs++;
                md_words++;
                if (md_words == PKT) begin
                    md_words    = 0;
                    md_pkts     = md_pkts + 1;
                    md_phase    = GAP;
                    md_gap_left = GAPC;
                end
            end
            default: begin
                md_gap_left--;
                if (md_gap_left == 0) md_phase = dma_ena ? ARMED : IDLE;
            end
        endcase
        @(posedge user_clk);
        #1;
    endtask

    task automatic go_idle();
        dma_ena        = 1'b0;
        fifo_prog_full = 1'b0;
        s_tvalid       = 1'b1;
        m_tready       = 1'b1;
        s_tlast        = 1'b0;
        for (int i = 0; i < 100 && md_phase != IDLE; i++) cycle();
        chk("go_idle_state", 64'(state_o), 64'(IDLE));
    endtask

    typedef struct {
        bit       ena, pf, tv, tr, tl;
        bit [1:0] st;
        bit       mv, sr, mtl;
    } vec_t;

    vec_t tbl[$];
    logic [DW-1:0] rx_data[$];
    bit            rx_tl[$];

    initial begin
        int n;
        int tl_idx;
        int tl_cnt;
        logic [DW-1:0] src_idx;

        user_rstn      = 1'b0;
        dma_ena        = 1'b0;
        fifo_prog_full = 1'b0;
        s_tdata        = 64'h1234_5678_9ABC_DEF0;
        s_tvalid       = 1'b1;
        s_tlast        = 1'b0;
        m_tready       = 1'b1;
        model_reset();

        // Basic packet as an explicit per-cycle table.
        tbl.push_back('{0, 0, 1, 1, 0, 2'd0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 2'd0, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 2'd1, 0, 0, 0});
        tbl.push_back('{1, 1, 1, 1, 0, 2'd1, 0, 0, 0});
        for (int i = 0; i < PKT; i++)
            tbl.push_back('{1, 0, 1, 1, i == PKT - 1, 2'd2, 1, 1, i == PKT - 1});
        for (int i = 0; i < GAPC; i++)
            tbl.push_back('{1, 0, 1, 1, 0, 2'd3, 0, 0, 0});
        tbl.push_back('{1, 0, 1, 1, 0, 2'd1, 0, 0, 0});

        #2;
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_pkt_count", 64'(pkt_count), 64'd0);
        chk("rst_frame_err", 64'(frame_err_count), 64'd0);
        chk("rst_tdata_follow", m_tdata, 64'h1234_5678_9ABC_DEF0);
        @(posedge user_clk);
        #1;
        user_rstn = 1'b1;

        foreach (tbl[i]) begin
            dma_ena        = tbl[i].ena;
            fifo_prog_full = tbl[i].pf;
            s_tvalid       = tbl[i].tv;
            m_tready       = tbl[i].tr;
            s_tlast        = tbl[i].tl;
            s_tdata        = {$urandom, $urandom};
            #1;
            chk($sformatf("tbl%0d_state", i), 64'(state_o), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_mvalid", i), 64'(m_tvalid), 64'(tbl[i].mv));
            chk($sformatf("tbl%0d_sready", i), 64'(s_tready), 64'(tbl[i].sr));
            chk($sformatf("tbl%0d_mtlast", i), 64'(m_tlast), 64'(tbl[i].mtl));
            cycle();
        end
        chk("basic_pkt_count", 64'(pkt_count), 64'd1);
        chk("basic_frame_err", 64'(frame_err_count), 64'd0);

        // Armed with valid data but no prog_full: nothing may leak.
        fifo_prog_full = 1'b0;
        s_tvalid       = 1'b1;
        m_tready       = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (obs_xfer) chk("noprog_leak", 64'(obs_xfer), 64'd0);
        end
        chk("noprog_state", 64'(state_o), 64'(ARMED));

        // Random backpressure over three packets; data is a running index.
        go_idle();
        dma_ena = 1'b1;
        cycle();
        rx_data.delete();
        rx_tl.delete();
        src_idx = '0;
        fifo_prog_full = 1'b1;
        for (int c = 0; c < 3000 && rx_data.size() < 3 * PKT; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = src_idx;
            s_tlast  = (src_idx % PKT) == PKT - 1;
            cycle();
            if (src_take) src_idx++;
            if (obs_xfer) begin
                rx_data.push_back(obs_data);
                rx_tl.push_back(obs_tl);
            end
        end
        dma_ena = 1'b0;
        chk("bp_word_total", 64'(rx_data.size()), 64'(3 * PKT));
        chk("bp_pkt_count", 64'(pkt_count), 64'd3);
        for (int i = 0; i < rx_data.size(); i++) begin
            if (rx_data[i] !== 64'(i)) chk($sformatf("bp_data%0d", i), rx_data[i], 64'(i));
            if (rx_tl[i] != ((i % PKT) == PKT - 1))
                chk($sformatf("bp_tlast%0d", i), 64'(rx_tl[i]), 64'((i % PKT) == PKT - 1));
        end

        // dma_ena dropped after word 5: packet completes, then the block stops.
        go_idle();
        dma_ena = 1'b1;
        cycle();
        fifo_prog_full = 1'b1;
        n = 0;
        for (int c = 0; c < 60; c++) begin
            s_tdata = {$urandom, $urandom};
            s_tlast = (n == PKT - 1);
            cycle();
            if (obs_xfer) n++;
            if (n == 5) dma_ena = 1'b0;
        end
        chk("stop_words", 64'(n), 64'(PKT));
        chk("stop_state", 64'(state_o), 64'(IDLE));

        // FIFO tlast on word 10 instead of 16.
        go_idle();
        dma_ena = 1'b1;
        cycle();
        fifo_prog_full = 1'b1;
        n      = 0;
        tl_idx = -1;
        tl_cnt = 0;
        for (int c = 0; c < 100 && n < PKT; c++) begin
            s_tlast = (n == 9);
            cycle();
            if (obs_xfer) begin
                if (obs_tl) begin
                    tl_idx = n;
                    tl_cnt++;
                end
                n++;
            end
        end
        s_tlast = 1'b0;
        chk("ferr_words", 64'(n), 64'(PKT));
        chk("ferr_count", 64'(frame_err_count), 64'd2);
        chk("ferr_out_tlast_idx", 64'(tl_idx), 64'(PKT - 1));
        chk("ferr_out_tlast_cnt", 64'(tl_cnt), 64'd1);
        chk("ferr_pkt_count", 64'(pkt_count), 64'd1);

        // Async reset in the middle of the second packet, then re-arm.
        go_idle();
        dma_ena = 1'b1;
        cycle();
        fifo_prog_full = 1'b1;
        s_tlast        = 1'b1;
        n = 0;
        for (int c = 0; c < 200 && n < PKT + 5; c++) begin
            cycle();
            if (obs_xfer) n++;
        end
        chk("rst_mid_words", 64'(n), 64'(PKT + 5));
        #3;
        user_rstn = 1'b0;
        #1;
        chk("arst_state", 64'(state_o), 64'd0);
        chk("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("arst_s_tready", 64'(s_tready), 64'd0);
        chk("arst_m_tlast", 64'(m_tlast), 64'd0);
        chk("arst_pkt_count", 64'(pkt_count), 64'd0);
        chk("arst_frame_err", 64'(frame_err_count), 64'd0);
        model_reset();
        @(posedge user_clk);
        #1;
        user_rstn = 1'b1;
        n      = 0;
        tl_idx = -1;
        for (int c = 0; c < 100 && n < PKT; c++) begin
            s_tlast = (n == PKT - 1);
            cycle();
            if (obs_xfer) begin
                if (obs_tl && tl_idx < 0) tl_idx = n;
                n++;
            end
        end
        chk("rearm_words", 64'(n), 64'(PKT));
        chk("rearm_tlast_idx", 64'(tl_idx), 64'(PKT - 1));
        chk("rearm_pkt_count", 64'(pkt_count), 64'd1);
        chk("rearm_frame_err", 64'(frame_err_count), 64'd0);

        // Free-running random traffic against the model.
        go_idle();
        for (int c = 0; c < 1500; c++) begin
            dma_ena        = ($urandom_range(0, 15) != 0);
            fifo_prog_full = 1'($urandom_range(0, 1));
            s_tvalid       = ($urandom_range(0, 3) != 0);
            m_tready       = ($urandom_range(0, 3) != 0);
            s_tlast        = ($urandom_range(0, 7) == 0);
            s_tdata        = {$urandom, $urandom};
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
